// File: rtl/vga_sink_monitor_if.sv
// Bus between the display path and the VGA sink monitor: video/control inputs
// driven by the source (master) and timing/checksum status returned by the monitor (slave).
interface vga_sink_monitor_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [3:0]  pix_r;
  logic [3:0]  pix_g;
  logic [3:0]  pix_b;
  logic        err_clr;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        active;
  logic        frame_done;
  logic [31:0] frame_sum;
  logic [15:0] frame_cnt;
  logic        locked;
  logic        h_err;
  logic        v_err;

  modport master (
    output pix_en, hsync, vsync, pix_r, pix_g, pix_b, err_clr,
    input  x_pos, y_pos, active, frame_done, frame_sum, frame_cnt,
           locked, h_err, v_err
  );

  modport slave (
    input  pix_en, hsync, vsync, pix_r, pix_g, pix_b, err_clr,
    output x_pos, y_pos, active, frame_done, frame_sum, frame_cnt,
           locked, h_err, v_err
  );
endinterface

// File: rtl/vga_sink_monitor.sv
// Receive-side VGA monitor: recovers pixel position from sync edges, checks line and
// frame timing, accumulates a per-frame pixel checksum and declares lock after clean frames.
module vga_sink_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_TOTAL     = 525,
  parameter int SYNC_ACT    = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst,
  vga_sink_monitor_if.slave io_vid
);

  localparam int CLEAN_W = $clog2(LOCK_FRAMES + 1);

  localparam logic              LP_ACT     = (SYNC_ACT != 0);
  localparam logic [9:0]        LP_X_LO    = 10'(H_SYNC + H_BP);
  localparam logic [9:0]        LP_X_HI    = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]        LP_Y_LO    = 10'(V_SYNC + V_BP);
  localparam logic [9:0]        LP_Y_HI    = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0]       LP_H_TOTAL = 11'(H_TOTAL);
  localparam logic [10:0]       LP_V_TOTAL = 11'(V_TOTAL);
  localparam logic [CLEAN_W-1:0] LP_LOCK   = CLEAN_W'(LOCK_FRAMES);
  localparam logic [CLEAN_W-1:0] LP_ONE    = CLEAN_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CLEAN_W-1:0]  r_clean;
  logic [CLEAN_W-1:0]  w_clean_nxt;
  logic [CLEAN_W-1:0]  w_clean_inc;

  logic        r_hs_prev;
  logic        r_vs_prev;
  logic        r_h_seen;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic        r_active;
  logic [31:0] r_acc;
  logic [31:0] r_frame_sum;
  logic [15:0] r_frame_cnt;
  logic        r_frame_done;
  logic        r_h_err;
  logic        r_v_err;

  logic        w_h_edge;
  logic        w_v_edge;
  logic [9:0]  w_x_nxt;
  logic [9:0]  w_y_nxt;
  logic        w_act_nxt;
  logic [10:0] w_line_len;
  logic [10:0] w_frame_lines;
  logic        w_h_bad;
  logic        w_v_bad;
  logic        w_boundary;
  logic [31:0] w_pix;
  logic [31:0] w_acc_sum;
  logic        w_locked;

  // Edges only exist on enabled samples, so everything downstream holds between enables.
  assign w_h_edge = io_vid.pix_en && (io_vid.hsync == LP_ACT) && (r_hs_prev != LP_ACT);
  assign w_v_edge = io_vid.pix_en && (io_vid.vsync == LP_ACT) && (r_vs_prev != LP_ACT);

  assign w_x_nxt = w_h_edge ? 10'd0 : ((r_x == 10'd1023) ? r_x : r_x + 10'd1);

  always_comb begin
    w_y_nxt = r_y;
    if (w_v_edge) begin
      w_y_nxt = 10'd0;
    end else if (w_h_edge && (r_y != 10'd1023)) begin
      w_y_nxt = r_y + 10'd1;
    end
  end

  assign w_act_nxt = (w_x_nxt >= LP_X_LO) && (w_x_nxt < LP_X_HI) &&
                     (w_y_nxt >= LP_Y_LO) && (w_y_nxt < LP_Y_HI);

  // The line ending at this edge spans the previous edge sample up to the last sample.
  assign w_line_len    = {1'b0, r_x} + 11'd1;
  assign w_frame_lines = {1'b0, r_y} + {10'd0, w_h_edge};

  assign w_h_bad    = w_h_edge && r_h_seen && (w_line_len != LP_H_TOTAL);
  assign w_boundary = w_v_edge && (r_state != ST_SEARCH);
  assign w_v_bad    = w_boundary && (w_frame_lines != LP_V_TOTAL);

  assign w_pix       = {20'd0, io_vid.pix_r, io_vid.pix_g, io_vid.pix_b};
  assign w_acc_sum   = r_acc + (w_act_nxt ? w_pix : 32'd0);
  assign w_clean_inc = r_clean + LP_ONE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_SEARCH;
      r_clean <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_clean <= w_clean_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clean_nxt = r_clean;
    case (r_state)
      ST_SEARCH: begin
        if (w_h_bad) begin
          w_clean_nxt = '0;
        end else if (w_v_edge) begin
          w_state_nxt = ST_MEASURE;
          w_clean_nxt = '0;
        end
      end
      ST_MEASURE: begin
        if (w_h_bad || w_v_bad) begin
          w_state_nxt = ST_SEARCH;
          w_clean_nxt = '0;
        end else if (w_v_edge) begin
          w_clean_nxt = w_clean_inc;
          if (w_clean_inc == LP_LOCK) begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (w_h_bad || w_v_bad) begin
          w_state_nxt = ST_SEARCH;
          w_clean_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
        w_clean_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_locked = (r_state == ST_LOCKED);
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hs_prev    <= LP_ACT;
      r_vs_prev    <= LP_ACT;
      r_h_seen     <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_active     <= 1'b0;
      r_acc        <= '0;
      r_frame_sum  <= '0;
      r_frame_cnt  <= '0;
      r_frame_done <= 1'b0;
      r_h_err      <= 1'b0;
      r_v_err      <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_h_err      <= (r_h_err && !io_vid.err_clr) || w_h_bad;
      r_v_err      <= (r_v_err && !io_vid.err_clr) || w_v_bad;
      if (io_vid.pix_en) begin
        r_hs_prev <= io_vid.hsync;
        r_vs_prev <= io_vid.vsync;
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_active  <= w_act_nxt;
        if (w_h_edge) begin
          r_h_seen <= 1'b1;
        end
        if (w_v_edge) begin
          r_acc <= '0;
          if (w_boundary) begin
            r_frame_sum  <= w_acc_sum;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
          end
        end else begin
          r_acc <= w_acc_sum;
        end
      end
    end
  end

  assign io_vid.x_pos      = r_x;
  assign io_vid.y_pos      = r_y;
  assign io_vid.active     = r_active;
  assign io_vid.frame_done = r_frame_done;
  assign io_vid.frame_sum  = r_frame_sum;
  assign io_vid.frame_cnt  = r_frame_cnt;
  assign io_vid.locked     = w_locked;
  assign io_vid.h_err      = r_h_err;
  assign io_vid.v_err      = r_v_err;

endmodule

// File: doc/vga_sink_monitor.md
Name: vga_sink_monitor

Overview:
- Receive-side endpoint for the game's VGA output (pix_r/pix_g/pix_b, hsync, vsync). It sits in the bench/debug path as the other end of the video interface.
- Recovers pixel position from the sync pulses and checks line/frame timing against 640x480@60 parameters.
- Accumulates a per-frame pixel checksum, so frame content can be compared in simulation and on-chip (ILA).
- Declares lock after consecutive clean frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines per frame
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- V_TOTAL, 525, lines per frame
- SYNC_ACT, 0, active level of hsync/vsync
- LOCK_FRAMES, 2, consecutive clean frames required to lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- pix_en  in  1  pixel-rate enable; all sampling happens only on cycles with pix_en=1
- hsync  in  1  horizontal sync from the display path
- vsync  in  1  vertical sync from the display path
- pix_r  in  4  red
- pix_g  in  4  green
- pix_b  in  4  blue
- err_clr  in  1  clears sticky errors (single-cycle pulse)
- x_pos  out  10  pixel index since last hsync assert edge
- y_pos  out  10  line index since last vsync assert edge
- active  out  1  current sample lies in the visible region
- frame_done  out  1  one-clk pulse at each frame boundary
- frame_sum  out  32  checksum of the last completed frame
- frame_cnt  out  16  completed-frame count, wraps
- locked  out  1  timing lock
- h_err  out  1  sticky line-length error
- v_err  out  1  sticky frame-length error

Behaviour:
- Reset (rst=0 at a clk edge) clears every output, counter, accumulator and edge register; the FSM goes to SEARCH.
- Reset wins over all other events, including mid-frame.
- Sampling:
  - Inputs are registered on pix_en cycles only; between enables all state holds.
  - The assert edge is defined as previous sample != SYNC_ACT and current sample == SYNC_ACT.
- Counters, advanced per enabled sample:
  - hsync assert edge: x <= 0, and y <= y+1. A vsync assert edge in the same sample overrides and sets y <= 0.
  - Otherwise x <= x+1, saturating at 1023.
- active = (H_SYNC+H_BP <= x < H_SYNC+H_BP+H_ACTIVE) and (V_SYNC+V_BP <= y < V_SYNC+V_BP+V_ACTIVE).
  - active is registered and valid one clk after the sample.
- Checksum:
  - On each active sample, acc <= acc + {pix_r,pix_g,pix_b}, zero-extended to 32 bits.
  - Addition is modulo 2^32.
- Line check, at each hsync assert edge after the first in SEARCH:
  - Samples since the previous edge must equal H_TOTAL.
  - On mismatch: h_err <= 1, the clean-frame count is cleared, and the FSM goes to SEARCH.
- Frame boundary, at a vsync assert edge:
  - frame_sum <= acc (including the sample in that cycle when active), then acc <= 0.
  - frame_done pulses for 1 clk.
  - frame_cnt <= frame_cnt+1.
  - The lines counted (hsync edges since the previous vsync edge) must equal V_TOTAL. Otherwise v_err <= 1 and the FSM goes to SEARCH.
  - The first vsync edge after SEARCH gives no frame_done; it only aligns.
- FSM:
  - SEARCH: waits for a vsync assert edge, then goes to MEASURE with clean=0.
  - MEASURE: each frame boundary with no h/v error increments clean. When clean == LOCK_FRAMES, go to LOCKED and assert locked.
  - LOCKED: any h/v error clears locked the next clk and goes to SEARCH.
- Sticky errors:
  - h_err and v_err clear only on reset or err_clr.
  - If err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- No pix_en at all: all state holds indefinitely, and locked holds its value.

Test Plan:
1. Ideal 800x525 timing, pix_en every 4th clk, constant pixel 0xFFF, 3 frames. Expect:
   - locked=1 after the 3rd vsync edge
   - frame_sum=1,257,984,000 (307200x4095)
   - frame_cnt=2
   - h_err=v_err=0
2. Gradient frame with pixel = x_visible mod 4096. Expect frame_sum = 480 x sum(0..639) = 98,150,400, and active high for exactly 307200 samples per frame.
3. Once locked, inject one 799-pixel line. Expect h_err=1 and locked=0 on the next clk; relock after 2 further clean frames while h_err stays 1; err_clr clears h_err.
4. Frame of 524 lines. Expect v_err=1, locked dropped, and frame_sum still latched for that frame.
5. Assert rst=0 for 1 clk mid-frame (y=200). Expect all outputs 0 and FSM in SEARCH; the first subsequent vsync edge produces no frame_done.
6. Hold pix_en=0 for 10,000 clks mid-line. Expect x_pos, y_pos and acc unchanged, locked stays 1, and no errors.
